alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand queue feeding an external combinational ALU,
// with a registered result stage and a transfer counter.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_op1,
  input  logic [31:0]     in_op2,
  input  logic [3:0]      in_opcode,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     alu_op1,
  output logic [31:0]     alu_op2,
  output logic [3:0]      alu_opcode,
  input  logic [31:0]     alu_result,
  input  logic            alu_carry,
  input  logic [63:0]     alu_product,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic            out_carry,
  output logic [63:0]     out_product,
  output logic [3:0]      out_opcode,
  output logic [TAGW-1:0] out_tag,
  output logic [15:0]     ops_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     op1_mem [DEPTH];
  logic [31:0]     op2_mem [DEPTH];
  logic [3:0]      opc_mem [DEPTH];
  logic [TAGW-1:0] tag_mem [DEPTH];

  logic            run_q, run_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_result_q, out_result_d;
  logic            out_carry_q, out_carry_d;
  logic [63:0]     out_product_q, out_product_d;
  logic [3:0]      out_opcode_q, out_opcode_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic empty, full, push, issue, out_xfer;
  logic is_mul, is_arith;
  logic [3:0]      head_opc;
  logic [TAGW-1:0] head_tag;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;

  // run_q holds off transfers for one edge after reset release
  assign push     = run_q && in_valid && in_ready;
  assign issue    = run_q && !empty && (!out_valid_q || out_ready);
  assign out_xfer = out_valid_q && out_ready;

  assign alu_op1    = empty ? '0 : op1_mem[rd_ptr_q];
  assign alu_op2    = empty ? '0 : op2_mem[rd_ptr_q];
  assign head_opc   = empty ? '0 : opc_mem[rd_ptr_q];
  assign head_tag   = empty ? '0 : tag_mem[rd_ptr_q];
  assign alu_opcode = head_opc;

  assign is_mul   = (head_opc == 4'd2);
  assign is_arith = (head_opc == 4'd0) || (head_opc == 4'd1) ||
                    (head_opc == 4'd3) || (head_opc == 4'd4);

  always_comb begin
    run_d    = 1'b1;
    wr_ptr_d = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(issue);
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_carry_d   = out_carry_q;
    out_product_d = out_product_q;
    out_opcode_d  = out_opcode_q;
    out_tag_d     = out_tag_q;
    ops_done_d    = out_xfer ? ops_done_q + 16'd1 : ops_done_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_opcode_d = head_opc;
      out_tag_d    = head_tag;
      unique case (1'b1)
        is_mul: begin
          out_result_d  = '0;
          out_carry_d   = 1'b0;
          out_product_d = alu_product;
        end
        is_arith: begin
          out_result_d  = alu_result;
          out_carry_d   = alu_carry;
          out_product_d = '0;
        end
        default: begin
          out_result_d  = alu_result;
          out_carry_d   = 1'b0;
          out_product_d = '0;
        end
      endcase
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op1_mem[wr_ptr_q] <= in_op1;
      op2_mem[wr_ptr_q] <= in_op2;
      opc_mem[wr_ptr_q] <= in_opcode;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_carry_q   <= 1'b0;
      out_product_q <= '0;
      out_opcode_q  <= '0;
      out_tag_q     <= '0;
      ops_done_q    <= '0;
    end else begin
      run_q         <= run_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_carry_q   <= out_carry_d;
      out_product_q <= out_product_d;
      out_opcode_q  <= out_opcode_d;
      out_tag_q     <= out_tag_d;
      ops_done_q    <= ops_done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_carry   = out_carry_q;
  assign out_product = out_product_q;
  assign out_opcode  = out_opcode_q;
  assign out_tag     = out_tag_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small external ALU model.
// Expected values are hand-computed per vector.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid, in_ready;
  logic [31:0]     in_op1, in_op2;
  logic [3:0]      in_opcode;
  logic [TAGW-1:0] in_tag;
  logic [31:0]     alu_op1, alu_op2;
  logic [3:0]      alu_opcode;
  logic [31:0]     alu_result;
  logic            alu_carry;
  logic [63:0]     alu_product;
  logic            out_valid, out_ready;
  logic [31:0]     out_result;
  logic            out_carry;
  logic [63:0]     out_product;
  logic [3:0]      out_opcode;
  logic [TAGW-1:0] out_tag;
  logic [15:0]     ops_done;

  int checks   = 0;
  int failures = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2),
    .in_opcode(in_opcode), .in_tag(in_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_product(alu_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_product(out_product), .out_opcode(out_opcode),
    .out_tag(out_tag), .ops_done(ops_done)
  );

  // External ALU; drives junk carry/product/result where capture must drop them
  always_comb begin
    alu_result  = '0;
    alu_carry   = 1'b0;
    alu_product = {32'd0, alu_op1} * {32'd0, alu_op2};
    case (alu_opcode)
      4'd0: {alu_carry, alu_result} = {1'b0, alu_op1} + {1'b0, alu_op2};
      4'd1: {alu_carry, alu_result} = {1'b0, alu_op1} - {1'b0, alu_op2};
      4'd2: begin alu_result = 32'hDEADBEEF; alu_carry = 1'b1; end
      4'd3: {alu_carry, alu_result} = {1'b0, alu_op1} + 33'd1;
      4'd4: {alu_carry, alu_result} = {1'b0, alu_op1} - 33'd1;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
        alu_result = alu_op1 ^ alu_op2;
        alu_carry  = 1'b1;
      end
      default: begin
        alu_result = alu_op1 << alu_op2[4:0];
        alu_carry  = 1'b1;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] opc,
                         input logic [TAGW-1:0] t, input logic [31:0] er,
                         input logic ec, input logic [63:0] ep);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op1    = a;
    in_op2    = b;
    in_opcode = opc;
    in_tag    = t;
    tick();
    in_valid = 1'b0;
    chk({nm, "_lat"}, out_valid, 0);
    tick();
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, out_result, er);
    chk({nm, "_carry"}, out_carry, ec);
    chk({nm, "_prod"}, out_product, ep);
    chk({nm, "_tag"}, out_tag, t);
    chk({nm, "_opc"}, out_opcode, opc);
    tick();
    exp_done++;
    chk({nm, "_done"}, ops_done, exp_done);
    chk({nm, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int n, vc, gaps, stale;
    bit seen, ended;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    in_opcode = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_done", ops_done, 0);
    chk("rst_res", out_result, 0);
    chk("rst_head", alu_op1, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_one("add", 32'hFFFFFFFF, 32'd1, 4'd0, 4'd3,
            32'd0, 1'b1, 64'd0);
    run_one("mul", 32'h10000, 32'h10000, 4'd2, 4'd5,
            32'd0, 1'b0, 64'h0000_0001_0000_0000);
    run_one("sub", 32'd5, 32'd7, 4'd1, 4'd6,
            32'hFFFFFFFE, 1'b1, 64'd0);
    run_one("xor", 32'hF0F0F0F0, 32'h0FF00FF0, 4'd5, 4'd7,
            32'hFF00FF00, 1'b0, 64'd0);
    run_one("shl", 32'd1, 32'd4, 4'd12, 4'd8,
            32'h10, 1'b0, 64'd0);

    // Backpressure: fill output register plus the whole queue
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid  = 1'b1;
      in_op1    = 32'(i * 10);
      in_op2    = '0;
      in_opcode = 4'd3;
      in_tag    = TAGW'(i);
      tick();
    end
    chk("bp_full", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_tag0", out_tag, 0);
    in_tag = 4'd9;
    repeat (2) tick();
    chk("bp_hold_tag", out_tag, 0);
    chk("bp_hold_res", out_result, 1);
    chk("bp_still_full", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        chk("bp_order_tag", out_tag, n);
        chk("bp_order_res", out_result, n * 10 + 1);
        n++;
      end
      tick();
    end
    exp_done += DEPTH + 1;
    chk("bp_count", n, DEPTH + 1);
    chk("bp_done", ops_done, exp_done);

    // Streaming
    vc = 0;
    gaps = 0;
    seen = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid  = (i < 20);
      in_op1    = 32'(i);
      in_opcode = 4'd0;
      in_tag    = TAGW'(i);
      tick();
      if (out_valid) begin
        vc++;
        if (ended) gaps++;
        seen = 1'b1;
      end else if (seen) begin
        ended = 1'b1;
      end
    end
    exp_done += 20;
    chk("stream_cycles", vc, 20);
    chk("stream_gaps", gaps, 0);
    chk("stream_done", ops_done, exp_done);

    // Reset with work in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_op1    = 32'(100 + i);
      in_opcode = 4'd3;
      in_tag    = TAGW'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_res", out_result, 0);
    chk("mid_tag", out_tag, 0);
    chk("mid_done", ops_done, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_head", alu_op1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("mid_stale", stale, 0);
    chk("mid_done_after", ops_done, 0);

    // Counter wrap
    in_valid  = 1'b1;
    in_opcode = 4'd0;
    repeat (65535) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_ffff", ops_done, 16'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_zero", ops_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
